trig_rx_monitor: RTL and testbench

Receive-side counterpart of the trigger generator. It sits on the board's trigger input, synchronises the asynchronous trigger line, and measures one burst of pulses after software arms it. For that burst it counts valid pulses, captures the last high width and the last rise-to-rise period, and flags glitches or a stuck-high line. A one-cycle done strobe marks the end of the burst, which is detected by an idle-gap timeout.

---
 rtl/trig_pkg.sv | 24 ++
 rtl/trig_sync_edge.sv | 40 ++++
 rtl/trig_rx_monitor.sv | 187 ++++++++++++++++++
 tb/tb_trig_rx_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
//==============================================================================
// Module      : trig_pkg
// Description : Shared state encoding and synchroniser depth for the trigger
//               receive monitor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package trig_pkg;

    // Number of flops between the asynchronous line and the level used by logic
    localparam int SYNC_DEPTH = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARMED = 3'd1;
    localparam state_t ST_HIGH  = 3'd2;
    localparam state_t ST_LOW   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage : trig_pkg

`default_nettype wire

// File: rtl/trig_sync_edge.sv
//==============================================================================
// Module      : trig_sync_edge
// Description : Two-flop synchroniser plus one delay flop for edge detection.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module trig_sync_edge
    import trig_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], async_i};
            dly_q  <= sync_q[SYNC_DEPTH-1];
        end
    end

    // Rise and fall both come from the same pair of flops, so both edges
    // see identical latency and measured widths stay exact.
    assign level_o = sync_q[SYNC_DEPTH-1];
    assign rise_o  =  sync_q[SYNC_DEPTH-1] & ~dly_q;
    assign fall_o  = ~sync_q[SYNC_DEPTH-1] &  dly_q;

endmodule : trig_sync_edge

`default_nettype wire

// File: rtl/trig_rx_monitor.sv
//==============================================================================
// Module      : trig_rx_monitor
// Description : Measures one armed burst on the trigger input: pulse count,
//               last width, last period, glitch/stuck-high error, done strobe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module trig_rx_monitor
    import trig_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int MINW_W = 8
) (
    input  logic              I_clk_100mhz,
    input  logic              I_Rst_n,
    input  logic              I_Trig,
    input  logic              I_Arm,
    input  logic [CNT_W-1:0]  I_Timeout,
    input  logic [MINW_W-1:0] I_Min_Width,
    output logic [CNT_W-1:0]  O_Pulse_Cnt,
    output logic [CNT_W-1:0]  O_Width,
    output logic [CNT_W-1:0]  O_Period,
    output logic              O_Err,
    output logic              O_Busy,
    output logic              O_Done
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + C_ONE;
    endfunction

    logic trig_level;
    logic trig_rise;
    logic trig_fall;

    trig_sync_edge u_sync (
        .clk_i   (I_clk_100mhz),
        .rst_ni  (I_Rst_n),
        .async_i (I_Trig),
        .level_o (trig_level),
        .rise_o  (trig_rise),
        .fall_o  (trig_fall)
    );

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  width_q,  width_d;
    logic [CNT_W-1:0]  per_q,    per_d;
    logic [CNT_W-1:0]  gap_q,    gap_d;
    logic [CNT_W-1:0]  tmo_q,    tmo_d;
    logic [MINW_W-1:0] minw_q,   minw_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [CNT_W-1:0]  wid_q,    wid_d;
    logic [CNT_W-1:0]  prd_q,    prd_d;
    logic              err_q,    err_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    always_ff @(posedge I_clk_100mhz or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            state_q <= ST_IDLE;
            width_q <= '0;
            per_q   <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            minw_q  <= '0;
            cnt_q   <= '0;
            wid_q   <= '0;
            prd_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            per_q   <= per_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            minw_q  <= minw_d;
            cnt_q   <= cnt_d;
            wid_q   <= wid_d;
            prd_q   <= prd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        per_d   = per_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        minw_d  = minw_q;
        cnt_d   = cnt_q;
        wid_d   = wid_q;
        prd_d   = prd_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (I_Arm) begin
                    cnt_d   = '0;
                    wid_d   = '0;
                    prd_d   = '0;
                    err_d   = 1'b0;
                    width_d = '0;
                    per_d   = '0;
                    gap_d   = '0;
                    tmo_d   = (I_Timeout == '0) ? C_ONE : I_Timeout;
                    minw_d  = I_Min_Width;
                    state_d = ST_ARMED;
                end
            end

            // A line already high at arm produces no rise here until it
            // has fallen and risen again.
            ST_ARMED: begin
                if (trig_rise) begin
                    width_d = C_ONE;
                    per_d   = C_ONE;
                    state_d = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (trig_fall) begin
                    if (width_q >= CNT_W'(minw_q)) begin
                        cnt_d = sat_inc(cnt_q);
                        wid_d = width_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    gap_d   = C_ONE;
                    per_d   = sat_inc(per_q);
                    state_d = ST_LOW;
                end else if (trig_level && (width_q >= tmo_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (trig_level) begin
                    width_d = sat_inc(width_q);
                    per_d   = sat_inc(per_q);
                end
            end

            ST_LOW: begin
                if (trig_rise) begin
                    prd_d   = per_q;
                    per_d   = C_ONE;
                    width_d = C_ONE;
                    state_d = ST_HIGH;
                end else if (gap_q >= tmo_q) begin
                    state_d = ST_DONE;
                end else begin
                    gap_d = sat_inc(gap_q);
                    per_d = sat_inc(per_q);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flag outputs are registered from the next state so they line up
        // exactly with the state register.
        busy_d = (state_d == ST_ARMED) || (state_d == ST_HIGH) || (state_d == ST_LOW);
        done_d = (state_d == ST_DONE);
    end

    assign O_Pulse_Cnt = cnt_q;
    assign O_Width     = wid_q;
    assign O_Period    = prd_q;
    assign O_Err       = err_q;
    assign O_Busy      = busy_q;
    assign O_Done      = done_q;

endmodule : trig_rx_monitor

`default_nettype wire

// File: tb/tb_trig_rx_monitor.sv
//==============================================================================
// Module      : tb_trig_rx_monitor
// Description : Self-checking bench for trig_rx_monitor with a result
//               scoreboard popped on every done strobe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_trig_rx_monitor;

    localparam int CNT_W  = 32;
    localparam int MINW_W = 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              trig  = 1'b0;
    logic              arm   = 1'b0;
    logic [CNT_W-1:0]  tmo   = '0;
    logic [MINW_W-1:0] minw  = '0;

    logic [CNT_W-1:0]  pulse_cnt;
    logic [CNT_W-1:0]  width;
    logic [CNT_W-1:0]  period;
    logic              err;
    logic              busy;
    logic              done;

    trig_rx_monitor #(.CNT_W(CNT_W), .MINW_W(MINW_W)) dut (
        .I_clk_100mhz (clk),
        .I_Rst_n      (rst_n),
        .I_Trig       (trig),
        .I_Arm        (arm),
        .I_Timeout    (tmo),
        .I_Min_Width  (minw),
        .O_Pulse_Cnt  (pulse_cnt),
        .O_Width      (width),
        .O_Period     (period),
        .O_Err        (err),
        .O_Busy       (busy),
        .O_Done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] wid;
        logic [31:0] prd;
        logic [31:0] err;
    } exp_t;

    exp_t sb[$];

    int n_chk     = 0;
    int n_fail    = 0;
    int last_fall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_arm(input logic [31:0] t, input logic [7:0] m);
        @(negedge clk);
        tmo  = t;
        minw = m;
        arm  = 1'b1;
        @(negedge clk);
        arm  = 1'b0;
    endtask

    // Called on a negedge; the line is high for exactly hi clock edges.
    task automatic pulse(input int hi, input int per);
        trig = 1'b1;
        tick(hi);
        trig = 1'b0;
        last_fall = cyc;
        tick(per - hi);
    endtask

    task automatic wait_done(input string tag, input int bound, input int ref_cyc,
                             input int lo, input int hi);
        bit   seen;
        int   d;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (seen) begin
                d = cyc - ref_cyc;
                if (d < lo || d > hi)
                    $display("  %s done latency %0d outside %0d..%0d", tag, d, lo, hi);
                chk({tag, "_done_lat_ok"}, 32'(d >= lo && d <= hi), 32'd1);
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                chk({tag, "_cnt"},    pulse_cnt, e.cnt);
                chk({tag, "_width"},  width,     e.wid);
                chk({tag, "_period"}, period,    e.prd);
                chk({tag, "_err"},    32'(err),  e.err);
                @(negedge clk);
                chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"},    pulse_cnt,  32'd0);
        chk({tag, "_width"},  width,      32'd0);
        chk({tag, "_period"}, period,     32'd0);
        chk({tag, "_err"},    32'(err),   32'd0);
        chk({tag, "_busy"},   32'(busy),  32'd0);
        chk({tag, "_done"},   32'(done),  32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_c;

        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(3);

        // Nominal burst
        do_arm(32'd2000, 8'd4);
        chk("nom_busy", 32'(busy), 32'd1);
        sb.push_back('{32'd5, 32'd24, 32'd1000, 32'd0});
        repeat (5) pulse(24, 1000);
        wait_done("nom", 3000, last_fall, 2000, 2003);
        tick(5);

        // Glitch then valid pulse
        do_arm(32'd2000, 8'd4);
        sb.push_back('{32'd1, 32'd24, 32'd500, 32'd1});
        pulse(2, 500);
        pulse(24, 500);
        wait_done("glitch", 3000, last_fall, 2000, 2003);
        tick(5);

        // Stuck-high
        do_arm(32'd100, 8'd4);
        sb.push_back('{32'd0, 32'd0, 32'd0, 32'd1});
        trig   = 1'b1;
        rise_c = cyc;
        wait_done("stuck", 300, rise_c, 100, 104);
        trig = 1'b0;
        tick(10);

        // Armed while the line is already high
        trig = 1'b1;
        tick(10);
        do_arm(32'd200, 8'd4);
        tick(48);
        trig = 1'b0;
        tick(20);
        sb.push_back('{32'd1, 32'd24, 32'd0, 32'd0});
        pulse(24, 40);
        wait_done("armhigh", 400, last_fall, 200, 203);
        tick(5);

        // Reset in the middle of a burst
        do_arm(32'd2000, 8'd4);
        repeat (3) pulse(24, 100);
        chk("rst_pre_cnt", pulse_cnt, 32'd3);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        repeat (2) pulse(24, 100);
        chk_all_zero("rst_noarm");

        // Arm request while busy must be ignored
        do_arm(32'd300, 8'd4);
        sb.push_back('{32'd2, 32'd24, 32'd100, 32'd0});
        trig = 1'b1;
        tick(24);
        trig = 1'b0;
        tick(30);
        tmo = 32'd5;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        chk("busyarm_cnt_kept", pulse_cnt, 32'd1);
        chk("busyarm_busy", 32'(busy), 32'd1);
        tick(45);
        pulse(24, 100);
        wait_done("busyarm", 1000, last_fall, 300, 303);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_trig_rx_monitor

`default_nettype wire
